sprite_rom_pal: RTL and testbench

Parametrised palette-indexed sprite ROM. It holds FRAMES frames of W x H pixels as IDX_W-bit palette indices, initialised from a MIF, and returns 24-bit RGB through a registered palette.
- Takes pixel coordinates plus a frame select, computes the address internally and flags out-of-bounds requests.
- Marks the transparent index for the sprite compositor.
- Sits between the VGA pixel scanner and the layer mixer.
- Next-generation replacement for the fixed single-image, fixed-palette sprite ROMs.

---
 rtl/sprite_pal_pkg.sv | 22 ++
 rtl/sprite_idx_mem.sv | 26 ++
 rtl/sprite_rom_pal.sv | 127 ++++++++++++
 tb/tb_sprite_rom_pal.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pal_pkg.sv
// sprite_pal_pkg: colour type, default palette and width helper shared by sprite_rom_pal.
package sprite_pal_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t PAL_DEFAULT [16] = '{
        24'hffffff, 24'h262828, 24'hbd874e, 24'h69441a,
        24'hbfbfbf, 24'h9a9b9d, 24'he9cfb8, 24'h322d24,
        24'hfcd36b, 24'hf47e21, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Palettes deeper than the default table fill with black.
    function automatic rgb_t pal_default(input int i);
        return (i >= 0 && i < 16) ? PAL_DEFAULT[i[3:0]] : '0;
    endfunction

endpackage

// File: rtl/sprite_idx_mem.sv
// sprite_idx_mem: palette-index memory initialised from a MIF, one port, registered read data.
module sprite_idx_mem #(
    parameter int    DEPTH    = 101400,
    parameter int    IDX_W    = 4,
    parameter int    ADDR_W   = 17,
    parameter string MIF_FILE = "sprite_rom_pal.mif"
) (
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_data,
    output logic [IDX_W-1:0]  rd_data
);

    (* ram_init_file = MIF_FILE *) logic [IDX_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] rd_data_q;

    // Write port is tied off by the top; it keeps the array a proper inferred RAM.
    always_ff @(posedge Clk) begin
        if (we) mem[addr] <= wr_data;
        rd_data_q <= mem[addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_rom_pal.sv
// sprite_rom_pal: multi-frame palette-indexed sprite ROM, 3-cycle pipeline to 24-bit RGB.
// Define SPRITE_ROM_PAL_WR_EN for a run-time writable palette; otherwise it is a constant ROM.
module sprite_rom_pal
    import sprite_pal_pkg::*;
#(
    parameter int    W          = 195,
    parameter int    H          = 130,
    parameter int    FRAMES     = 4,
    parameter int    IDX_W      = 4,
    parameter int    TRANSP_IDX = 0,
    parameter string MIF_FILE   = "sprite_rom_pal.mif",
    localparam int   XW         = clog2_min1(W),
    localparam int   YW         = clog2_min1(H),
    localparam int   FW         = clog2_min1(FRAMES),
    localparam int   DEPTH      = FRAMES * W * H,
    localparam int   ADDR_W     = clog2_min1(DEPTH),
    localparam int   PAL_N      = 2 ** IDX_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             req_valid,
    input  logic [XW-1:0]    x,
    input  logic [YW-1:0]    y,
    input  logic [FW-1:0]    frame,
`ifdef SPRITE_ROM_PAL_WR_EN
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_idx,
    input  logic [23:0]      pal_data,
`endif
    output logic             pix_valid,
    output logic [23:0]      pix_rgb,
    output logic             pix_transp,
    output logic             pix_oob
);

    logic              v1_q, v1_d, oob1_q, oob1_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic              v2_q, v2_d, oob2_q, oob2_d;
    logic              pix_valid_q, pix_valid_d, pix_transp_q, pix_transp_d, pix_oob_q, pix_oob_d;
    rgb_t              pix_rgb_q, pix_rgb_d;
    logic [IDX_W-1:0]  idx;
    rgb_t              pal_rd;
    int unsigned       xu, yu, fu;

    // Bounds are checked on full-width copies so no bit of the request is lost.
    assign xu = 32'(x);
    assign yu = 32'(y);
    assign fu = 32'(frame);

    always_comb begin
        v1_d         = req_valid;
        oob1_d       = (xu >= W) | (yu >= H) | (fu >= FRAMES);
        addr1_d      = oob1_d ? '0 : ADDR_W'(fu * W * H + yu * W + xu);
        v2_d         = v1_q;
        oob2_d       = oob1_q;
        pix_valid_d  = v2_q;
        pix_rgb_d    = v2_q ? (oob2_q ? '0 : pal_rd) : pix_rgb_q;
        pix_transp_d = v2_q ? (oob2_q | (idx == IDX_W'(TRANSP_IDX))) : pix_transp_q;
        pix_oob_d    = v2_q ? oob2_q : pix_oob_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q         <= 1'b0;
            oob1_q       <= 1'b0;
            addr1_q      <= '0;
            v2_q         <= 1'b0;
            oob2_q       <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_rgb_q    <= '0;
            pix_transp_q <= 1'b0;
            pix_oob_q    <= 1'b0;
        end else begin
            v1_q         <= v1_d;
            oob1_q       <= oob1_d;
            addr1_q      <= addr1_d;
            v2_q         <= v2_d;
            oob2_q       <= oob2_d;
            pix_valid_q  <= pix_valid_d;
            pix_rgb_q    <= pix_rgb_d;
            pix_transp_q <= pix_transp_d;
            pix_oob_q    <= pix_oob_d;
        end
    end

    sprite_idx_mem #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .ADDR_W   (ADDR_W),
        .MIF_FILE (MIF_FILE)
    ) u_mem (
        .Clk     (Clk),
        .addr    (addr1_q),
        .we      (1'b0),
        .wr_data ('0),
        .rd_data (idx)
    );

`ifdef SPRITE_ROM_PAL_WR_EN
    rgb_t pal_q [PAL_N];
    rgb_t pal_d [PAL_N];

    // Lookups read pal_q, so a same-cycle write to the looked-up entry returns the old colour.
    always_comb begin
        for (int i = 0; i < PAL_N; i++)
            pal_d[i] = (pal_we && pal_idx == IDX_W'(i)) ? pal_data : pal_q[i];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_default(i);
        end else begin
            for (int i = 0; i < PAL_N; i++) pal_q[i] <= pal_d[i];
        end
    end

    assign pal_rd = pal_q[idx];
`else
    assign pal_rd = pal_default(int'(idx));
`endif

    assign pix_valid  = pix_valid_q;
    assign pix_rgb    = pix_rgb_q;
    assign pix_transp = pix_transp_q;
    assign pix_oob    = pix_oob_q;

endmodule

// File: tb/tb_sprite_rom_pal.sv
// tb_sprite_rom_pal: directed self-checking bench for sprite_rom_pal with mem[a] = a mod 16.
module tb_sprite_rom_pal;

    logic        Clk, Reset_n, req_valid;
    logic [7:0]  x, y;
    logic [1:0]  frame;
    logic        pix_valid, pix_transp, pix_oob;
    logic [23:0] pix_rgb;
`ifdef SPRITE_ROM_PAL_WR_EN
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [23:0] pal_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [23:0] pal_exp [16] = '{
        24'hffffff, 24'h262828, 24'hbd874e, 24'h69441a,
        24'hbfbfbf, 24'h9a9b9d, 24'he9cfb8, 24'h322d24,
        24'hfcd36b, 24'hf47e21, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    // Expected pipeline: slot 0 is the newest request, slot 2 is the one due at the output.
    logic        ev [3];
    logic [23:0] er [3];
    logic        et [3], eo [3];
    string       etag [3];
    logic [23:0] hr;
    logic        ht, ho;

    sprite_rom_pal dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_valid  (req_valid),
        .x          (x),
        .y          (y),
        .frame      (frame),
`ifdef SPRITE_ROM_PAL_WR_EN
        .pal_we     (pal_we),
        .pal_idx    (pal_idx),
        .pal_data   (pal_data),
`endif
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .pix_transp (pix_transp),
        .pix_oob    (pix_oob)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0; er[i] = '0; et[i] = 1'b0; eo[i] = 1'b0; etag[i] = "idle";
        end
        hr = '0; ht = 1'b0; ho = 1'b0;
    endtask

    task automatic push(input logic v, input logic [7:0] px, input logic [7:0] py, input logic [1:0] pf,
                        input logic [23:0] rgb, input logic t, input logic o, input string tag);
        req_valid = v; x = px; y = py; frame = pf;
        for (int i = 2; i > 0; i--) begin
            ev[i] = ev[i-1]; er[i] = er[i-1]; et[i] = et[i-1]; eo[i] = eo[i-1]; etag[i] = etag[i-1];
        end
        ev[0] = v; er[0] = rgb; et[0] = t; eo[0] = o; etag[0] = tag;
        @(posedge Clk); #1;
        if (ev[2]) begin
            hr = er[2]; ht = et[2]; ho = eo[2];
        end
        check({etag[2], "_valid"},  32'(pix_valid),  32'(ev[2]));
        check({etag[2], "_rgb"},    32'(pix_rgb),    32'(hr));
        check({etag[2], "_transp"}, 32'(pix_transp), 32'(ht));
        check({etag[2], "_oob"},    32'(pix_oob),    32'(ho));
    endtask

    task automatic idle();
        push(1'b0, 8'd0, 8'd0, 2'd0, 24'h0, 1'b0, 1'b0, "idle");
    endtask

    initial begin
        Reset_n = 1'b0; req_valid = 1'b0; x = '0; y = '0; frame = '0;
`ifdef SPRITE_ROM_PAL_WR_EN
        pal_we = 1'b0; pal_idx = '0; pal_data = '0;
`endif
        flush_model();
        for (int a = 0; a < 101400; a++) dut.u_mem.mem[a] = 4'(a % 16);
        repeat (2) @(posedge Clk);
        #1;
        check("reset_valid",  32'(pix_valid),  32'd0);
        check("reset_rgb",    32'(pix_rgb),    32'd0);
        check("reset_transp", 32'(pix_transp), 32'd0);
        check("reset_oob",    32'(pix_oob),    32'd0);
        Reset_n = 1'b1;
        idle();

        for (int i = 0; i < 16; i++)
            push(1'b1, 8'(i), 8'd0, 2'd0, pal_exp[i], i == 0, 1'b0, $sformatf("stream%0d", i));

        // frame 2,y1,x3 -> 50898 -> idx 2; frame 2,y0,x3 -> 50703 -> idx 15; frame 3 last -> 101399 -> idx 7
        push(1'b1, 8'd3,   8'd1,   2'd2, 24'hbd874e, 1'b0, 1'b0, "f2y1x3");
        push(1'b1, 8'd3,   8'd0,   2'd2, 24'h000000, 1'b0, 1'b0, "f2y0x3");
        push(1'b1, 8'd194, 8'd129, 2'd3, 24'h322d24, 1'b0, 1'b0, "f3last");

        push(1'b1, 8'd195, 8'd0,   2'd0, 24'h000000, 1'b1, 1'b1, "oob_x");
        push(1'b1, 8'd0,   8'd130, 2'd0, 24'h000000, 1'b1, 1'b1, "oob_y");
        push(1'b1, 8'd255, 8'd255, 2'd3, 24'h000000, 1'b1, 1'b1, "oob_xy");
        // frame 1,y0,x3 -> 25353 -> idx 9
        push(1'b1, 8'd3,   8'd0,   2'd1, 24'hf47e21, 1'b0, 1'b0, "after_oob");

        push(1'b1, 8'd4, 8'd0, 2'd0, 24'hbfbfbf, 1'b0, 1'b0, "gap_a");
        idle();
        push(1'b1, 8'd6, 8'd0, 2'd0, 24'he9cfb8, 1'b0, 1'b0, "gap_b");
        push(1'b1, 8'd8, 8'd0, 2'd0, 24'hfcd36b, 1'b0, 1'b0, "gap_c");
        idle();
        idle();
        idle();

        push(1'b1, 8'd1, 8'd0, 2'd0, 24'h262828, 1'b0, 1'b0, "rst_a");
        push(1'b1, 8'd2, 8'd0, 2'd0, 24'hbd874e, 1'b0, 1'b0, "rst_b");
        Reset_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("async_rst_valid", 32'(pix_valid), 32'd0);
        check("async_rst_rgb",   32'(pix_rgb),   32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        flush_model();
        idle();
        idle();
        idle();
        push(1'b1, 8'd5, 8'd0, 2'd0, 24'h9a9b9d, 1'b0, 1'b0, "post_rst");
        idle();
        idle();
        idle();

`ifdef SPRITE_ROM_PAL_WR_EN
        push(1'b1, 8'd2, 8'd0, 2'd0, 24'hbd874e, 1'b0, 1'b0, "pw_old");
        idle();
        pal_we = 1'b1; pal_idx = 4'd2; pal_data = 24'h123456;
        idle();
        pal_we = 1'b0;
        push(1'b1, 8'd2, 8'd0, 2'd0, 24'h123456, 1'b0, 1'b0, "pw_new");
        idle();
        idle();
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        flush_model();
        push(1'b1, 8'd2, 8'd0, 2'd0, 24'hbd874e, 1'b0, 1'b0, "pw_rst");
        idle();
        idle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
